// File: rtl/a2d_sched.sv
// Round-robin scheduler for four ADC channels over a shared SPI monarch.
// Each conversion takes two SPI words: a command, then a read-back.
module a2d_sched #(
  parameter logic [2:0] CH_LFT   = 3'd0,
  parameter logic [2:0] CH_RGHT  = 3'd4,
  parameter logic [2:0] CH_STEER = 3'd5,
  parameter logic [2:0] CH_BATT  = 3'd6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        busy,
  output logic        cnv_cmplt
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CMD_WAIT = 2'd1;
  localparam logic [1:0] GAP      = 2'd2;
  localparam logic [1:0] RD_WAIT  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        wrt_q, wrt_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cnv_cmplt_q, cnv_cmplt_d;
  logic [11:0] lft_ld_q, lft_ld_d;
  logic [11:0] rght_ld_q, rght_ld_d;
  logic [11:0] steer_pot_q, steer_pot_d;
  logic [11:0] batt_q, batt_d;
  logic [2:0]  ch_sel;

  // The ADC only returns a 12-bit result; the top nibble is don't-care.
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_data[15:12];

  always_comb begin
    ch_sel = CH_LFT;
    case (ptr_q)
      2'd0:    ch_sel = CH_LFT;
      2'd1:    ch_sel = CH_RGHT;
      2'd2:    ch_sel = CH_STEER;
      default: ch_sel = CH_BATT;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wrt_d       = 1'b0;
    cmd_d       = cmd_q;
    cnv_cmplt_d = 1'b0;
    lft_ld_d    = lft_ld_q;
    rght_ld_d   = rght_ld_q;
    steer_pot_d = steer_pot_q;
    batt_d      = batt_q;
    case (state_q)
      IDLE: begin
        if (nxt) begin
          state_d = CMD_WAIT;
          wrt_d   = 1'b1;
          cmd_d   = {2'b00, ch_sel, 11'h000};
        end
      end
      CMD_WAIT: begin
        if (done) state_d = GAP;
      end
      GAP: begin
        // Second word re-sends the same cmd to clock out the result.
        wrt_d   = 1'b1;
        state_d = RD_WAIT;
      end
      default: begin
        if (done) begin
          case (ptr_q)
            2'd0:    lft_ld_d    = rd_data[11:0];
            2'd1:    rght_ld_d   = rd_data[11:0];
            2'd2:    steer_pot_d = rd_data[11:0];
            default: batt_d      = rd_data[11:0];
          endcase
          cnv_cmplt_d = 1'b1;
          ptr_d       = ptr_q + 2'd1;
          state_d     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      wrt_q       <= 1'b0;
      cmd_q       <= 16'h0000;
      cnv_cmplt_q <= 1'b0;
      lft_ld_q    <= 12'h000;
      rght_ld_q   <= 12'h000;
      steer_pot_q <= 12'h000;
      batt_q      <= 12'h000;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wrt_q       <= wrt_d;
      cmd_q       <= cmd_d;
      cnv_cmplt_q <= cnv_cmplt_d;
      lft_ld_q    <= lft_ld_d;
      rght_ld_q   <= rght_ld_d;
      steer_pot_q <= steer_pot_d;
      batt_q      <= batt_d;
    end
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign cnv_cmplt = cnv_cmplt_q;
  assign busy      = (state_q != IDLE);
  assign lft_ld    = lft_ld_q;
  assign rght_ld   = rght_ld_q;
  assign steer_pot = steer_pot_q;
  assign batt      = batt_q;

endmodule

// File: doc/a2d_sched.md
A2D_SCHED -- requirements
Module: a2d_sched

Interface
REQ-001 SHALL have parameter CH_LFT, default 3'd0, ADC channel for left load cell.
REQ-002 SHALL have parameter CH_RGHT, default 3'd4, ADC channel for right load cell.
REQ-003 SHALL have parameter CH_STEER, default 3'd5, ADC channel for steering pot.
REQ-004 SHALL have parameter CH_BATT, default 3'd6, ADC channel for battery.
REQ-005 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port nxt  input  1  single-cycle request to convert the next channel.
REQ-008 SHALL have port wrt  output  1  single-cycle start pulse to the shared SPI monarch.
REQ-009 SHALL have port cmd  output  16  SPI word sent with wrt.
REQ-010 SHALL have port done  input  1  single-cycle SPI transaction-complete pulse.
REQ-011 SHALL have port rd_data  input  16  SPI word received, valid when done=1.
REQ-012 SHALL have port lft_ld  output  12  latest left load-cell sample.
REQ-013 SHALL have port rght_ld  output  12  latest right load-cell sample.
REQ-014 SHALL have port steer_pot  output  12  latest steering-pot sample.
REQ-015 SHALL have port batt  output  12  latest battery sample.
REQ-016 SHALL have port busy  output  1  high from nxt acceptance until cnv_cmplt.
REQ-017 SHALL have port cnv_cmplt  output  1  single-cycle pulse when a sample register updates.

Function
REQ-018 SHALL implement FSM states IDLE, CMD_WAIT, GAP, RD_WAIT.
REQ-019 SHALL maintain 2-bit round-robin pointer ptr, order 0=LFT, 1=RGHT, 2=STEER, 3=BATT, wrapping 3->0.
REQ-020 SHALL drive cmd = {2'b00, ch[2:0], 11'h000}, ch selected by ptr; cmd stable from wrt until cnv_cmplt.
REQ-021 IDLE with nxt=1: SHALL pulse wrt the next cycle (registered), set busy, go to CMD_WAIT.
REQ-022 CMD_WAIT with done=1: SHALL go to GAP, rd_data ignored.
REQ-023 GAP: SHALL hold exactly 1 cycle, then pulse wrt (same cmd), go to RD_WAIT.
REQ-024 RD_WAIT with done=1: SHALL load rd_data[11:0] into the register selected by ptr, pulse cnv_cmplt, advance ptr, clear busy, return to IDLE, all visible the cycle after done.
REQ-025 SHALL ignore nxt while busy=1 (no queuing, no ptr change).
REQ-026 SHALL ignore done in IDLE and GAP.
REQ-027 nxt and done in same cycle of RD_WAIT: SHALL complete current conversion only; nxt dropped.
REQ-028 SHALL leave non-selected sample registers unchanged on completion.
REQ-029 SHALL pulse wrt exactly twice per conversion; wrt never high two consecutive cycles.
REQ-030 Minimum nxt-to-cnv_cmplt latency, done returning one cycle after each wrt: 6 cycles.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, ptr=0, wrt=0, busy=0, cnv_cmplt=0, cmd=16'h0000, all sample registers 12'h000.
REQ-032 rst asserted mid-conversion SHALL abort it with no register update; first nxt after release converts CH_LFT.

Verification
REQ-033 Reset release, nxt pulse, SPI model returns 16'h0300 -> wrt twice with cmd 16'h0000, lft_ld=12'h300, one cnv_cmplt.
REQ-034 Four nxt pulses, returns 16'h0301/0302/0503/0A00 -> cmds 16'h0000/16'h2000/16'h2800/16'h3000, lft_ld=12'h301, rght_ld=12'h302, steer_pot=12'h503, batt=12'hA00; fifth nxt uses cmd 16'h0000.
REQ-035 nxt pulsed every cycle during a conversion -> exactly one cnv_cmplt, ptr advances by 1.
REQ-036 rst pulsed during RD_WAIT of channel 2 -> all samples 12'h000, next conversion uses cmd 16'h0000.
REQ-037 Spurious done in IDLE -> no wrt, no register change, busy stays 0.
REQ-038 rd_data=16'hF123 on read -> sample=12'h123 (upper 4 bits discarded).
